alu_op_issue: RTL and testbench
===============================

ALU_OP_ISSUE -- requirements
Module: alu_op_issue

Interface
REQ-001 The block SHALL have parameter OPCODE_LENGTH, default 4, meaning the width of the Operation code it produces for the ALU.
REQ-002 The block SHALL have parameter TAG_WIDTH, default 5, meaning the width of the opaque tag carried alongside each operation.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning an asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, meaning an upstream instruction is presented.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts the presented instruction this cycle.
REQ-007 The block SHALL have ports opcode, funct3 and funct7, all inputs, of widths 7, 3 and 7, meaning the RISC-V instruction fields.
REQ-008 The block SHALL have port in_tag, input, TAG_WIDTH, meaning the tag travelling with the instruction.
REQ-009 The block SHALL have port out_valid, output, 1, meaning a decoded operation is presented downstream.
REQ-010 The block SHALL have port out_ready, input, 1, meaning downstream consumes the presented operation.
REQ-011 The block SHALL have port Operation, output, OPCODE_LENGTH, meaning the ALU operation code.
REQ-012 The block SHALL have ports IsBranch and Illegal, both outputs of width 1, and out_tag, an output of width TAG_WIDTH.
REQ-013 The block SHALL have port illegal_count, output, 16, meaning the number of illegal instructions accepted.

Function
REQ-014 The input handshake SHALL transfer when in_valid && in_ready; the output handshake SHALL transfer when out_valid && out_ready.
REQ-015 Decode encodings SHALL be: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, EQ 1000, GE 1001, NE 1010, LTU 1100.
REQ-016 For opcode 0110011, decode SHALL map funct3 000 with funct7 0000000 to ADD and with funct7 0100000 to SUB.
REQ-017 For opcode 0110011, decode SHALL map 111 to AND, 110 to OR, 100 to XOR, 001 with funct7=0 to SLL, 101 with funct7=0 to SRL, 101 with funct7 0100000 to SRA, and 011 to LTU.
REQ-018 For opcode 0010011, decode SHALL follow the same mapping as REQ-016 and REQ-017, except that funct3 000 SHALL be ADD regardless of funct7.
REQ-019 Opcodes 0000011, 0100011, 1100111, 1101111, 0110111 and 0010111 SHALL decode to ADD.
REQ-020 Opcode 1100011 SHALL decode funct3 000 to EQ, 001 to NE, 101 to GE and 110 to LTU, with IsBranch=1.
REQ-021 Every other combination, including funct3 010, unlisted funct7 values and undefined opcodes, SHALL produce Operation=1111, Illegal=1 and IsBranch=0.
REQ-022 The datapath SHALL consist of one output register stage plus one skid register; latency from input transfer to out_valid SHALL be 1 cycle when the output stage is empty or draining.
REQ-023 in_ready SHALL equal NOT skid_valid, with no combinational path from out_ready to in_ready.
REQ-024 If the output stage holds an entry, is stalled (out_ready=0) and an input transfers, the decoded entry SHALL go to the skid register.
REQ-025 When the output transfers and the skid register is full, the skid entry SHALL move to the output stage on the same edge.
REQ-026 Order SHALL be preserved, and throughput SHALL be one operation per cycle while out_ready=1.
REQ-027 Outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-028 illegal_count SHALL increment on each input transfer with an illegal decode and SHALL saturate at 0xFFFF.

Reset
REQ-029 Asserting reset SHALL immediately set out_valid=0, the skid register empty, in_ready=1, Operation=0000, IsBranch=0, Illegal=0, out_tag=0 and illegal_count=0.
REQ-030 Reset mid-stream SHALL discard all held entries; no transfer SHALL occur in any cycle in which reset is high.

Verification
REQ-031 A bench SHALL drive opcode 0110011, funct3 000, funct7 0100000, tag 3, with out_ready=1, and SHALL observe Operation=0110 and out_tag=3 with out_valid one cycle later.
REQ-032 A bench SHALL drive opcode 1100011 with funct3 101, and SHALL observe Operation=1001 and IsBranch=1.
REQ-033 A bench SHALL drive opcode 0110011 with funct3 010, and SHALL observe Operation=1111, Illegal=1 and illegal_count incremented from 0 to 1.
REQ-034 A bench SHALL hold out_ready=0 and stream tags 1, 2 and 3, and SHALL observe tag 1 held on the output, tag 2 in skid, in_ready=0, and tag 3 not accepted; after releasing out_ready it SHALL observe tags 1, 2, 3 in order.
REQ-035 A bench SHALL assert reset while two entries are held, and SHALL observe out_valid=0 and in_ready=1 immediately, with no stale tag emitted after release.
REQ-036 A bench SHALL accept 65537 illegal instructions, and SHALL observe illegal_count=0xFFFF.

Source files
------------

// File: rtl/alu_op_issue.sv
// Purpose: decode RISC-V opcode/funct3/funct7 into an ALU operation code and issue it
//          downstream with its tag through one output register backed by one skid register.
// Latency: 1 cycle from input transfer to out_valid when the output stage is empty or draining.
// Backpressure: in_ready = !skid_valid (registered, no combinational path from out_ready);
//               a stalled output absorbs exactly one more entry into the skid register.
// Ports: clk, reset (async active-high); in_valid/in_ready with opcode, funct3, funct7, in_tag;
//        out_valid/out_ready with Operation, IsBranch, Illegal, out_tag; illegal_count (saturating).
module alu_op_issue #(
    parameter int OPCODE_LENGTH = 4,
    parameter int TAG_WIDTH     = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic [6:0]               funct7,
    input  logic [TAG_WIDTH-1:0]     in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     IsBranch,
    output logic                     Illegal,
    output logic [TAG_WIDTH-1:0]     out_tag,
    output logic [15:0]              illegal_count
);

    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0110);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b0111);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_GE  = OPCODE_LENGTH'(4'b1001);
    localparam logic [OPCODE_LENGTH-1:0] OP_NE  = OPCODE_LENGTH'(4'b1010);
    localparam logic [OPCODE_LENGTH-1:0] OP_LTU = OPCODE_LENGTH'(4'b1100);
    localparam logic [OPCODE_LENGTH-1:0] OP_ILL = {OPCODE_LENGTH{1'b1}};

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Decoded form of the instruction currently on the input
    logic [OPCODE_LENGTH-1:0] dec_op;
    logic                     dec_br;
    logic                     dec_ill;

    always_comb begin
        dec_op = OP_ILL;
        dec_br = 1'b0;
        unique case (opcode)
            7'b0110011, 7'b0010011: begin
                unique case (funct3)
                    3'b000: begin
                        // Immediate form has no SUB; funct7 bits there are immediate data
                        if (opcode == 7'b0010011 || funct7 == F7_ZERO) dec_op = OP_ADD;
                        else if (funct7 == F7_ALT)                    dec_op = OP_SUB;
                    end
                    3'b111: dec_op = OP_AND;
                    3'b110: dec_op = OP_OR;
                    3'b100: dec_op = OP_XOR;
                    3'b011: dec_op = OP_LTU;
                    3'b001: if (funct7 == F7_ZERO) dec_op = OP_SLL;
                    3'b101: begin
                        if (funct7 == F7_ZERO)     dec_op = OP_SRL;
                        else if (funct7 == F7_ALT) dec_op = OP_SRA;
                    end
                    default: dec_op = OP_ILL;
                endcase
            end
            // Address generation for loads, stores, jumps and upper-immediates
            7'b0000011, 7'b0100011, 7'b1100111,
            7'b1101111, 7'b0110111, 7'b0010111: dec_op = OP_ADD;
            7'b1100011: begin
                dec_br = 1'b1;
                unique case (funct3)
                    3'b000:  dec_op = OP_EQ;
                    3'b001:  dec_op = OP_NE;
                    3'b101:  dec_op = OP_GE;
                    3'b110:  dec_op = OP_LTU;
                    default: begin
                        dec_op = OP_ILL;
                        dec_br = 1'b0;
                    end
                endcase
            end
            default: dec_op = OP_ILL;
        endcase
        dec_ill = (dec_op == OP_ILL);
    end

    logic                     out_vld_q, out_vld_d;
    logic [OPCODE_LENGTH-1:0] out_op_q,  out_op_d;
    logic                     out_br_q,  out_br_d;
    logic                     out_ill_q, out_ill_d;
    logic [TAG_WIDTH-1:0]     out_tag_q, out_tag_d;
    logic                     skid_vld_q, skid_vld_d;
    logic [OPCODE_LENGTH-1:0] skid_op_q,  skid_op_d;
    logic                     skid_br_q,  skid_br_d;
    logic                     skid_ill_q, skid_ill_d;
    logic [TAG_WIDTH-1:0]     skid_tag_q, skid_tag_d;
    logic [15:0]              ill_cnt_q,  ill_cnt_d;

    logic in_fire;
    logic out_fire;

    assign in_ready = ~skid_vld_q;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_vld_q & out_ready;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_op_d   = out_op_q;
        out_br_d   = out_br_q;
        out_ill_d  = out_ill_q;
        out_tag_d  = out_tag_q;
        skid_vld_d = skid_vld_q;
        skid_op_d  = skid_op_q;
        skid_br_d  = skid_br_q;
        skid_ill_d = skid_ill_q;
        skid_tag_d = skid_tag_q;
        ill_cnt_d  = ill_cnt_q;

        if (!out_vld_q || out_fire) begin
            // Output stage free this edge: oldest entry (skid first) takes it.
            // in_fire cannot coincide with a full skid, so nothing is lost here.
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_op_d   = skid_op_q;
                out_br_d   = skid_br_q;
                out_ill_d  = skid_ill_q;
                out_tag_d  = skid_tag_q;
                skid_vld_d = 1'b0;
            end else if (in_fire) begin
                out_vld_d = 1'b1;
                out_op_d  = dec_op;
                out_br_d  = dec_br;
                out_ill_d = dec_ill;
                out_tag_d = in_tag;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (in_fire) begin
            // Output stalled and holding: park the new entry in the skid register
            skid_vld_d = 1'b1;
            skid_op_d  = dec_op;
            skid_br_d  = dec_br;
            skid_ill_d = dec_ill;
            skid_tag_d = in_tag;
        end

        if (in_fire && dec_ill && ill_cnt_q != 16'hFFFF) begin
            ill_cnt_d = ill_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_vld_q  <= 1'b0;
            out_op_q   <= '0;
            out_br_q   <= 1'b0;
            out_ill_q  <= 1'b0;
            out_tag_q  <= '0;
            skid_vld_q <= 1'b0;
            skid_op_q  <= '0;
            skid_br_q  <= 1'b0;
            skid_ill_q <= 1'b0;
            skid_tag_q <= '0;
            ill_cnt_q  <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_op_q   <= out_op_d;
            out_br_q   <= out_br_d;
            out_ill_q  <= out_ill_d;
            out_tag_q  <= out_tag_d;
            skid_vld_q <= skid_vld_d;
            skid_op_q  <= skid_op_d;
            skid_br_q  <= skid_br_d;
            skid_ill_q <= skid_ill_d;
            skid_tag_q <= skid_tag_d;
            ill_cnt_q  <= ill_cnt_d;
        end
    end

    assign out_valid     = out_vld_q;
    assign Operation     = out_op_q;
    assign IsBranch      = out_br_q;
    assign Illegal       = out_ill_q;
    assign out_tag       = out_tag_q;
    assign illegal_count = ill_cnt_q;

endmodule

// File: tb/tb_alu_op_issue.sv
module tb_alu_op_issue;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] in_tag;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] Operation;
    logic       IsBranch;
    logic       Illegal;
    logic [4:0] out_tag;
    logic [15:0] illegal_count;

    alu_op_issue #(.OPCODE_LENGTH(4), .TAG_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .Operation(Operation),
        .IsBranch(IsBranch), .Illegal(Illegal), .out_tag(out_tag),
        .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] op;
        logic       br;
        logic       ill;
        logic [4:0] tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [6:0] R_T = 7'b0110011;
    localparam logic [6:0] I_T = 7'b0010011;
    localparam logic [6:0] B_T = 7'b1100011;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Present one instruction, wait for acceptance, record its expected decode
    task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] tag, input logic [3:0] eop, input logic ebr,
                        input logic eill);
        bit   ok;
        exp_t e;
        in_valid = 1'b1; opcode = opc; funct3 = f3; funct7 = f7; in_tag = tag;
        ok = 1'b0;
        for (int w = 0; w < 50 && !ok; w++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_accept tag=%0d in_ready actual=0 required=1", tag);
        end else begin
            e.op = eop; e.br = ebr; e.ill = eill; e.tag = tag;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int w = 0; w < 40 && !done; w++) begin
            @(posedge clk); #1;
            if (sb_q.size() == 0 && !out_valid) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain pending actual=%0d required=0", sb_q.size());
        end
    endtask

    // Scoreboard monitor: every output transfer must match the oldest expected entry
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (!reset && out_valid && out_ready) begin
            checks++;
            a = {Operation, IsBranch, Illegal, out_tag};
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected actual op=%b tag=%0d required no output", Operation, out_tag);
            end else begin
                e = sb_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL out_entry actual op=%b br=%b ill=%b tag=%0d required op=%b br=%b ill=%b tag=%0d",
                             a.op, a.br, a.ill, a.tag, e.op, e.br, e.ill, e.tag);
                end
            end
        end
    end

    initial begin
        int acc;
        int cyc;
        reset = 1'b1; in_valid = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
        in_tag = '0; out_ready = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_operation", Operation, 0);
        chk("rst_isbranch", IsBranch, 0);
        chk("rst_illegal", Illegal, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_illegal_count", illegal_count, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;

        // SUB, visible one cycle after the transfer edge
        send(R_T, 3'b000, 7'b0100000, 5'd3, 4'b0110, 1'b0, 1'b0);
        chk("sub_out_valid", out_valid, 1);
        chk("sub_operation", Operation, 4'b0110);
        chk("sub_out_tag", out_tag, 3);

        // BGE
        send(B_T, 3'b101, 7'b0000000, 5'd4, 4'b1001, 1'b1, 1'b0);
        chk("bge_operation", Operation, 4'b1001);
        chk("bge_isbranch", IsBranch, 1);

        // Illegal funct3 010 bumps the counter 0 -> 1
        chk("cnt_before", illegal_count, 0);
        send(R_T, 3'b010, 7'b0000000, 5'd5, 4'b1111, 1'b0, 1'b1);
        chk("ill_operation", Operation, 4'b1111);
        chk("ill_illegal", Illegal, 1);
        chk("cnt_after", illegal_count, 1);

        // Decode table, back-to-back
        send(R_T, 3'b000, 7'b0000000, 5'd6,  4'b0010, 1'b0, 1'b0); // ADD
        send(R_T, 3'b111, 7'b0000000, 5'd7,  4'b0000, 1'b0, 1'b0); // AND
        send(R_T, 3'b110, 7'b0000000, 5'd8,  4'b0001, 1'b0, 1'b0); // OR
        send(R_T, 3'b100, 7'b0000000, 5'd9,  4'b0011, 1'b0, 1'b0); // XOR
        send(R_T, 3'b001, 7'b0000000, 5'd10, 4'b0100, 1'b0, 1'b0); // SLL
        send(R_T, 3'b101, 7'b0000000, 5'd11, 4'b0101, 1'b0, 1'b0); // SRL
        send(R_T, 3'b101, 7'b0100000, 5'd12, 4'b0111, 1'b0, 1'b0); // SRA
        send(R_T, 3'b011, 7'b0000000, 5'd13, 4'b1100, 1'b0, 1'b0); // LTU
        send(R_T, 3'b000, 7'b0000001, 5'd14, 4'b1111, 1'b0, 1'b1); // bad funct7
        send(R_T, 3'b001, 7'b0100000, 5'd15, 4'b1111, 1'b0, 1'b1); // bad funct7 on SLL
        send(I_T, 3'b000, 7'b0100000, 5'd16, 4'b0010, 1'b0, 1'b0); // ADDI, any funct7
        send(I_T, 3'b101, 7'b0100000, 5'd17, 4'b0111, 1'b0, 1'b0); // SRAI
        send(I_T, 3'b010, 7'b0000000, 5'd18, 4'b1111, 1'b0, 1'b1); // I-type 010
        send(7'b0000011, 3'b010, 7'b0000000, 5'd19, 4'b0010, 1'b0, 1'b0); // load
        send(7'b0100011, 3'b010, 7'b0000000, 5'd20, 4'b0010, 1'b0, 1'b0); // store
        send(7'b1100111, 3'b000, 7'b0000000, 5'd21, 4'b0010, 1'b0, 1'b0); // jalr
        send(7'b1101111, 3'b000, 7'b0000000, 5'd22, 4'b0010, 1'b0, 1'b0); // jal
        send(7'b0110111, 3'b000, 7'b0000000, 5'd23, 4'b0010, 1'b0, 1'b0); // lui
        send(7'b0010111, 3'b000, 7'b0000000, 5'd24, 4'b0010, 1'b0, 1'b0); // auipc
        send(B_T, 3'b000, 7'b0000000, 5'd25, 4'b1000, 1'b1, 1'b0); // BEQ
        send(B_T, 3'b001, 7'b0000000, 5'd26, 4'b1010, 1'b1, 1'b0); // BNE
        send(B_T, 3'b110, 7'b0000000, 5'd27, 4'b1100, 1'b1, 1'b0); // BLTU
        send(B_T, 3'b100, 7'b0000000, 5'd28, 4'b1111, 1'b0, 1'b1); // unsupported branch
        send(7'b1111111, 3'b000, 7'b0000000, 5'd29, 4'b1111, 1'b0, 1'b1); // bad opcode
        drain();
        chk("cnt_table", illegal_count, 6);

        // Stall: tag1 on output, tag2 in skid, tag3 refused
        out_ready = 1'b0;
        send(R_T, 3'b000, 7'b0000000, 5'd1, 4'b0010, 1'b0, 1'b0);
        send(R_T, 3'b111, 7'b0000000, 5'd2, 4'b0000, 1'b0, 1'b0);
        in_valid = 1'b1; opcode = R_T; funct3 = 3'b110; funct7 = '0; in_tag = 5'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_tag", out_tag, 1);
            chk("stall_operation", Operation, 4'b0010);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(R_T, 3'b110, 7'b0000000, 5'd3, 4'b0001, 1'b0, 1'b0);
        drain();

        // Reset with two entries held discards both
        out_ready = 1'b0;
        send(R_T, 3'b000, 7'b0000000, 5'd7, 4'b0010, 1'b0, 1'b0);
        send(R_T, 3'b000, 7'b0000000, 5'd8, 4'b0010, 1'b0, 1'b0);
        chk("held_in_ready", in_ready, 0);
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_cnt", illegal_count, 0);

        // 65537 illegal instructions at full rate; counter saturates
        @(posedge clk); #1;
        in_valid = 1'b1; opcode = 7'b1111111; funct3 = '0; funct7 = '0; in_tag = 5'd9;
        acc = 0;
        cyc = 0;
        while (acc < 65537 && cyc < 70000) begin
            @(negedge clk);
            cyc++;
            if (in_ready) begin
                exp_t e;
                e.op = 4'b1111; e.br = 1'b0; e.ill = 1'b1; e.tag = 5'd9;
                sb_q.push_back(e);
                acc++;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("sat_accepted", acc, 65537);
        chk("sat_throughput_cycles", cyc, 65537);
        chk("sat_count", illegal_count, 16'hFFFF);
        drain();
        chk("final_sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
